// File: rtl/tart_bb_sequencer.sv
// Block buffer sequencer: drains the acquisition FIFO into the block buffer,
// then streams the buffer in address order into the transmit FIFO under watermark throttling.
module tart_bb_sequencer #(
    parameter int BLOCK_BUFFER_ADDR_WIDTH = 14,
    parameter int BLOCK_BUFFER_DEPTH      = 1 << BLOCK_BUFFER_ADDR_WIDTH,
    parameter int TX_CNT_WIDTH            = 5,
    parameter int TX_HIGH_WATER           = 24
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_aq_i,
    input  logic                               aq_empty_i,
    output logic                               aq_read_en_o,
    output logic                               bb_write_en_o,
    output logic [BLOCK_BUFFER_ADDR_WIDTH-1:0] bb_write_ptr_o,
    output logic [BLOCK_BUFFER_ADDR_WIDTH-1:0] bb_read_ptr_o,
    input  logic [TX_CNT_WIDTH-1:0]            tx_wr_count_i,
    input  logic                               tx_full_i,
    output logic                               tx_write_en_o,
    output logic                               bb_filled_o,
    output logic                               readout_done_o,
    output logic [1:0]                         state_o
);

    localparam int AW = BLOCK_BUFFER_ADDR_WIDTH;
    localparam logic [AW:0]             DEPTH_C   = (AW+1)'(BLOCK_BUFFER_DEPTH);
    localparam logic [AW:0]             ONE_C     = (AW+1)'(1);
    localparam logic [AW-1:0]           ONE_A     = AW'(1);
    localparam logic [AW-1:0]           LAST_ADDR = {AW{1'b1}};
    localparam logic [TX_CNT_WIDTH-1:0] TX_THRESH = TX_CNT_WIDTH'(TX_HIGH_WATER - 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [AW:0]   rd_issued_q, rd_issued_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          wr_en_q, wr_en_d;
    logic [AW:0]   rd_bb_issued_q, rd_bb_issued_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          tx_en_q, tx_en_d;
    logic [AW:0]   tx_written_q, tx_written_d;
    logic          filled_q, filled_d;
    logic          done_q, done_d;
    logic          start_evt;
    logic          aq_read_en;
    logic          rd_issue;

    always_comb begin
        start_evt  = s2_q & ~s3_q;
        aq_read_en = (state_q == ST_CAPTURE) & ~aq_empty_i & (rd_issued_q < DEPTH_C);
        // Threshold leaves room for one write in flight plus one cycle of count lag.
        rd_issue   = (state_q == ST_DRAIN) & ~tx_full_i & (tx_wr_count_i < TX_THRESH)
                   & (rd_bb_issued_q < DEPTH_C);

        state_d        = state_q;
        rd_issued_d    = rd_issued_q;
        wr_ptr_d       = wr_ptr_q;
        wr_en_d        = aq_read_en;
        rd_bb_issued_d = rd_bb_issued_q;
        rd_ptr_d       = rd_ptr_q;
        tx_en_d        = rd_issue;
        tx_written_d   = tx_written_q;
        filled_d       = filled_q;
        done_d         = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_evt) begin
                    state_d        = ST_CAPTURE;
                    rd_issued_d    = '0;
                    wr_ptr_d       = '0;
                    rd_bb_issued_d = '0;
                    rd_ptr_d       = '0;
                    tx_written_d   = '0;
                    filled_d       = 1'b0;
                    done_d         = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (aq_read_en) begin
                    rd_issued_d = rd_issued_q + ONE_C;
                end
                // FIFO data lags the read by one cycle, so the write trails the read strobe.
                if (wr_en_q) begin
                    wr_ptr_d = wr_ptr_q + ONE_A;
                    if (wr_ptr_q == LAST_ADDR) begin
                        filled_d = 1'b1;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (rd_issue) begin
                    rd_ptr_d       = rd_ptr_q + ONE_A;
                    rd_bb_issued_d = rd_bb_issued_q + ONE_C;
                end
                if (tx_en_q) begin
                    tx_written_d = tx_written_q + ONE_C;
                    if (tx_written_q == {1'b0, LAST_ADDR}) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            rd_issued_q    <= '0;
            wr_ptr_q       <= '0;
            wr_en_q        <= 1'b0;
            rd_bb_issued_q <= '0;
            rd_ptr_q       <= '0;
            tx_en_q        <= 1'b0;
            tx_written_q   <= '0;
            filled_q       <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= start_aq_i;
            s2_q           <= s1_q;
            s3_q           <= s2_q;
            rd_issued_q    <= rd_issued_d;
            wr_ptr_q       <= wr_ptr_d;
            wr_en_q        <= wr_en_d;
            rd_bb_issued_q <= rd_bb_issued_d;
            rd_ptr_q       <= rd_ptr_d;
            tx_en_q        <= tx_en_d;
            tx_written_q   <= tx_written_d;
            filled_q       <= filled_d;
            done_q         <= done_d;
        end
    end

    assign aq_read_en_o   = aq_read_en;
    assign bb_write_en_o  = wr_en_q;
    assign bb_write_ptr_o = wr_ptr_q;
    assign bb_read_ptr_o  = rd_ptr_q;
    assign tx_write_en_o  = tx_en_q;
    assign bb_filled_o    = filled_q;
    assign readout_done_o = done_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_tart_bb_sequencer.sv
// Bench for tart_bb_sequencer (ADDR_WIDTH=4): vector table, hand sequences and random
// stimulus against a count-based reference model plus an end-to-end data path check.
module tb_tart_bb_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int HW    = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_aq;
    logic          aq_empty;
    logic [4:0]    tx_wr_count;
    logic          tx_full;
    logic          aq_read_en, bb_write_en, tx_write_en, bb_filled, readout_done;
    logic [AW-1:0] bb_write_ptr, bb_read_ptr;
    logic [1:0]    state;

    tart_bb_sequencer #(
        .BLOCK_BUFFER_ADDR_WIDTH(AW),
        .BLOCK_BUFFER_DEPTH(DEPTH),
        .TX_CNT_WIDTH(5),
        .TX_HIGH_WATER(HW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_aq_i(start_aq), .aq_empty_i(aq_empty),
        .aq_read_en_o(aq_read_en), .bb_write_en_o(bb_write_en),
        .bb_write_ptr_o(bb_write_ptr), .bb_read_ptr_o(bb_read_ptr),
        .tx_wr_count_i(tx_wr_count), .tx_full_i(tx_full), .tx_write_en_o(tx_write_en),
        .bb_filled_o(bb_filled), .readout_done_o(readout_done), .state_o(state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus event counts; pointers are counts modulo DEPTH.
    int  m_phase;      // 0 idle, 1 capture, 2 drain, 3 done
    bit  m_s [3];      // start samples, newest first
    int  m_reads, m_writes, m_bbrd, m_txw;
    bit  m_pw, m_pt, m_filled, m_done;
    // Data path: bench-side acquisition FIFO and block buffer contents
    logic [31:0]   mem [DEPTH];
    logic [31:0]   fifo_dout;
    logic [AW-1:0] prev_rptr;
    int            word_cnt, tx_seen;

    task automatic model_reset();
        m_phase = 0; m_s[0] = 0; m_s[1] = 0; m_s[2] = 0;
        m_reads = 0; m_writes = 0; m_bbrd = 0; m_txw = 0;
        m_pw = 0; m_pt = 0; m_filled = 0; m_done = 0;
        fifo_dout = '0; prev_rptr = '0; word_cnt = 0; tx_seen = 0;
    endtask

    function automatic bit exp_aq();
        return m_phase == 1 && !aq_empty && m_reads < DEPTH;
    endfunction

    function automatic bit exp_issue();
        return m_phase == 2 && !tx_full && int'(tx_wr_count) < HW - 2 && m_bbrd < DEPTH;
    endfunction

    task automatic model_advance();
        bit evt, aq, iss;
        if (rst) begin
            model_reset();
            return;
        end
        evt = m_s[1] && !m_s[2];
        aq  = exp_aq();
        iss = exp_issue();
        m_s[2] = m_s[1]; m_s[1] = m_s[0]; m_s[0] = start_aq;
        if ((m_phase == 0 || m_phase == 3) && evt) begin
            m_phase = 1; m_reads = 0; m_writes = 0; m_bbrd = 0; m_txw = 0;
            m_filled = 0; m_done = 0; word_cnt = 0; tx_seen = 0;
        end else begin
            if (m_pw) begin
                m_writes++;
                if (m_writes == DEPTH) begin m_phase = 2; m_filled = 1; end
            end
            if (aq) m_reads++;
            if (m_pt) begin
                m_txw++;
                if (m_txw == DEPTH) begin m_phase = 3; m_done = 1; end
            end
            if (iss) m_bbrd++;
        end
        m_pw = aq;
        m_pt = iss;
    endtask

    // One clock: inputs were driven at the preceding negedge; check, then advance.
    task automatic tick();
        #1;
        if (rst) model_reset();
        chk("state",        32'(state),        32'(m_phase));
        chk("aq_read_en",   32'(aq_read_en),   32'(exp_aq()));
        chk("bb_write_en",  32'(bb_write_en),  32'(m_pw));
        chk("bb_write_ptr", 32'(bb_write_ptr), 32'(m_writes % DEPTH));
        chk("bb_read_ptr",  32'(bb_read_ptr),  32'(m_bbrd % DEPTH));
        chk("tx_write_en",  32'(tx_write_en),  32'(m_pt));
        chk("bb_filled",    32'(bb_filled),    32'(m_filled));
        chk("readout_done", 32'(readout_done), 32'(m_done));
        if (bb_write_en === 1'b1) mem[bb_write_ptr] = fifo_dout;
        if (tx_write_en === 1'b1) begin
            chk("tx_data_order", mem[prev_rptr], 32'(tx_seen));
            tx_seen++;
        end
        prev_rptr = bb_read_ptr;
        if (aq_read_en === 1'b1) begin
            fifo_dout = 32'(word_cnt);
            word_cnt++;
        end
        model_advance();
        @(negedge clk);
    endtask

    typedef struct {
        logic       start;
        logic       aq_empty;
        logic [4:0] tx_cnt;
        logic       tx_full;
        int         n;
        int         st;
        int         wptr;
        int         rptr;
        logic       filled;
        logic       done;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // start, aq_empty, tx_cnt, tx_full, cycles -> state, wptr, rptr, filled, done
        tbl[0]  = '{1'b1, 1'b1, 5'd0,  1'b1,  3, 1, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 5'd0,  1'b1,  5, 1, 0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'd0,  1'b1,  5, 1, 4, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 5'd0,  1'b1,  4, 1, 5, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 5'd0,  1'b1, 14, 2, 0, 0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 5'd22, 1'b0,  6, 2, 0, 0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 5'd21, 1'b1,  4, 2, 0, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5'd21, 1'b0,  5, 2, 0, 5, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 5'd0,  1'b0, 13, 3, 0, 0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 5'd0,  1'b1,  3, 1, 0, 0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 5'd0,  1'b1, 20, 2, 0, 0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 5'd0,  1'b1,  2, 2, 0, 0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 5'd0,  1'b0, 20, 3, 0, 0, 1'b1, 1'b1};

        rst = 1'b1; start_aq = 1'b0; aq_empty = 1'b0; tx_wr_count = '0; tx_full = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_state",        32'(state),        32'd0);
        chk("reset_aq_read_en",   32'(aq_read_en),   32'd0);
        chk("reset_bb_write_en",  32'(bb_write_en),  32'd0);
        chk("reset_bb_write_ptr", 32'(bb_write_ptr), 32'd0);
        chk("reset_bb_read_ptr",  32'(bb_read_ptr),  32'd0);
        chk("reset_tx_write_en",  32'(tx_write_en),  32'd0);
        chk("reset_filled_done",  32'({bb_filled, readout_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0; aq_empty = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 13; i++) begin
            start_aq = tbl[i].start; aq_empty = tbl[i].aq_empty;
            tx_wr_count = tbl[i].tx_cnt; tx_full = tbl[i].tx_full;
            repeat (tbl[i].n) tick();
            chk($sformatf("vec%0d_state", i),  32'(state),        32'(tbl[i].st));
            chk($sformatf("vec%0d_wptr", i),   32'(bb_write_ptr), 32'(tbl[i].wptr));
            chk($sformatf("vec%0d_rptr", i),   32'(bb_read_ptr),  32'(tbl[i].rptr));
            chk($sformatf("vec%0d_filled", i), 32'(bb_filled),    32'(tbl[i].filled));
            chk($sformatf("vec%0d_done", i),   32'(readout_done), 32'(tbl[i].done));
        end

        // 10-cycle start pulse from DONE must start exactly once
        start_aq = 1'b1; aq_empty = 1'b0; tx_full = 1'b1; tx_wr_count = '0;
        repeat (10) tick();
        chk("pulse_no_double_start_wptr", 32'(bb_write_ptr), 32'd6);
        start_aq = 1'b0;
        repeat (14) tick();
        chk("pulse_capture_to_drain", 32'(state), 32'd2);
        // start rises during drain and is still high in DONE: no retrigger
        tx_full = 1'b0; start_aq = 1'b1;
        repeat (25) tick();
        chk("held_start_stays_done", 32'(state), 32'd3);
        // single-cycle glitch is caught once sampled by the first flop
        start_aq = 1'b0;
        repeat (3) tick();
        start_aq = 1'b1;
        tick();
        start_aq = 1'b0;
        repeat (2) tick();
        chk("glitch_start", 32'(state), 32'd1);

        // asynchronous reset mid-capture, then a clean restart from address 0
        aq_empty = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("rst_state",       32'(state),        32'd0);
        chk("rst_aq_read_en",  32'(aq_read_en),   32'd0);
        chk("rst_bb_write_en", 32'(bb_write_en),  32'd0);
        chk("rst_wptr",        32'(bb_write_ptr), 32'd0);
        chk("rst_tx_write_en", 32'(tx_write_en),  32'd0);
        chk("rst_filled",      32'(bb_filled),    32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        start_aq = 1'b1;
        repeat (3) tick();
        chk("restart_state", 32'(state), 32'd1);
        tick();
        chk("restart_first_write_en", 32'(bb_write_en),  32'd1);
        chk("restart_first_wptr",     32'(bb_write_ptr), 32'd0);

        // randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            aq_empty    = ($urandom_range(0, 3) == 0);
            tx_full     = ($urandom_range(0, 7) == 0);
            tx_wr_count = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(18, 24))
                                                       : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 11) == 0) start_aq = ~start_aq;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
